if_id_fetch: RTL
================

Name: if_id_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the ID/EX pipe.
- Owns the PC and issues requests to instruction memory with a req/ack handshake.
- Holds a fetched word in a one-entry skid buffer while decode is stalled.
- Redirects on jr and flushes the IF/ID register to a NOP bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- stall_in  in  1  decode hazard stall; hold IF/ID contents and PC
- jr_in  in  1  redirect request (jr resolved downstream)
- jr_target_in  in  32  redirect address; bits [1:0] ignored and forced to 0
- imem_req_out  out  1  fetch request valid
- imem_addr_out  out  32  fetch address (current PC)
- imem_rdata_in  in  32  fetched instruction word
- imem_ack_in  in  1  rdata valid for the address presented this cycle
- ins_out  out  32  IF/ID instruction to decode
- pc_plus4_out  out  32  PC+4 of ins_out
- valid_out  out  1  ins_out is a real instruction; 0 means bubble

Behaviour:
- State register with three states:
  - S_RESET: entered on rst.
  - S_FETCH: imem_req_out=1, imem_addr_out=pc.
  - S_HOLD: imem_req_out=0, a word is held in the skid buffer.
- Reset values, applied on the posedge where rst=1 (sync, no other effect that cycle):
  - state=S_RESET, pc=RESET_PC.
  - ins_out=32'h0 (sll $0 NOP), pc_plus4_out=0, valid_out=0.
  - skid buffer=0, skid_valid=0, imem_req_out=0.
- Initial block sets the same values, for simulation only.
- S_RESET -> S_FETCH on the first cycle with rst=0. The first request appears 1 cycle after reset deasserts.
- Priority per cycle: rst > jr_in > stall_in > ack.
- jr_in=1, in any non-reset state:
  - pc <= {jr_target_in[31:2],2'b00}.
  - ins_out <= 0, valid_out <= 0, skid_valid <= 0.
  - Any same-cycle ack is discarded; state <= S_FETCH.
  - jr overrides stall_in: the flush still happens and the bubble goes into IF/ID.
- S_FETCH, ack=1, stall=0:
  - ins_out <= rdata, pc_plus4_out <= pc+4, valid_out <= 1, pc <= pc+4.
  - Stay in S_FETCH.
- S_FETCH, ack=1, stall=1:
  - skid <= rdata, skid_valid <= 1, state <= S_HOLD.
  - IF/ID outputs and pc unchanged.
- S_FETCH, ack=0, stall=0: ins_out <= 0, valid_out <= 0 (bubble); pc unchanged; request held.
- S_FETCH, ack=0, stall=1: everything holds.
- S_HOLD:
  - While stall=1, hold everything. imem_ack_in is ignored.
  - On stall=0: ins_out <= skid, pc_plus4_out <= pc+4, valid_out <= 1, pc <= pc+4, skid_valid <= 0, state <= S_FETCH.
- Latency: ack at cycle n gives ins_out valid at cycle n+1. One word per cycle when ack is held high and there is no stall.
- Arithmetic: pc+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- imem contract: ack refers only to the address presented in the same cycle. The block never has more than one request outstanding.
- Reset mid-HOLD or mid-request: skid contents are lost, and the fetch restarts at RESET_PC.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- When defined, adds two outputs:
  - fetch_count_out [CNT_W-1:0]: increments each cycle valid_out is loaded with 1.
  - flush_count_out [CNT_W-1:0]: increments on each jr_in flush.
- Both counters saturate at all-ones and clear on rst.
- When undefined, these ports and registers do not exist and the block behaves identically otherwise.

Decomposition:
- Shared package cpu_pkg:
  - fetch-state enum (S_RESET, S_FETCH, S_HOLD).
  - NOP_INS = 32'h0.
  - INS_W = 32.
  - PC_INC = 4.
- The ID/EX pipe and later stages reuse NOP_INS and INS_W.
- Sub-module fetch_skid_buf: one-entry 32-bit buffer with load, take and clear inputs, and a valid flag. It is natural to split out and is reused by later stalled stages.

Test Plan:
- Reset release: rst 1 for 2 cycles, then ack held 1 with imem returning addr+32'h100 -> req at cycle 1 after release with addr=0; ins_out=32'h100, 32'h104, 32'h108 on consecutive cycles; pc_plus4_out=4, 8, 12.
- Stall with skid: ack=1, stall=1 at pc=8 -> state S_HOLD, ins_out frozen, req=0. Release stall 3 cycles later -> ins_out=rdata(8), pc=12, valid=1.
- jr during stall: S_HOLD at pc=16 with jr_in=1, jr_target_in=32'h0000_0043 -> next cycle pc=32'h40, valid_out=0, ins_out=0, skid cleared; next fetch addr=32'h40.
- Memory wait: ack=0 for 4 cycles at pc=20 -> 4 bubbles (valid_out=0), addr stays 20; ack on cycle 5 -> ins_out=rdata(20).
- Wrap: RESET_PC=32'hFFFF_FFFC with ack=1 -> pc_plus4_out=0, next addr=0.
- With IF_ID_PERF_CNT_EN, CNT_W=4: 20 fetches then 2 jr -> fetch_count_out=15 (saturated), flush_count_out=2; rst clears both to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline types and constants for the fetch and later stages.
package cpu_pkg;
  localparam int INS_W = 32;
  localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry instruction buffer with load/take/clear and a valid flag.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             take,
  input  logic [INS_W-1:0] din,
  output logic [INS_W-1:0] data,
  output logic             valid
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data  <= NOP_INS;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (take) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/if_id_fetch.sv
// if_id_fetch: PC, imem req/ack fetch and IF/ID register with skid buffer and jr flush.
// Optional saturating fetch/flush counters when IF_ID_PERF_CNT_EN is defined.
module if_id_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_in,
  input  logic             jr_in,
  input  logic [31:0]      jr_target_in,
  output logic             imem_req_out,
  output logic [31:0]      imem_addr_out,
  input  logic [INS_W-1:0] imem_rdata_in,
  input  logic             imem_ack_in,
  output logic [INS_W-1:0] ins_out,
  output logic [31:0]      pc_plus4_out,
  output logic             valid_out
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] fetch_count_out,
  output logic [CNT_W-1:0] flush_count_out
`endif
);
  if (RESET_PC[1:0] != 2'b00 || CNT_W < 1) begin : g_bad_param
    $error("if_id_fetch: bad parameter");
  end
  fetch_state_t     state, state_nx;
  logic [31:0]      pc, pc_nx, pc4_nx;
  logic [INS_W-1:0] ins_nx, skid;
  logic             valid_nx, skid_valid, load, take, flush, fetch;
  fetch_skid_buf u_skid (
    .clk  (clk),
    .rst  (rst),
    .clear(flush),
    .load (load),
    .take (take),
    .din  (imem_rdata_in),
    .data (skid),
    .valid(skid_valid)
  );
  assign imem_req_out  = state == S_FETCH;
  assign imem_addr_out = pc;
  // Priority: jr > stall > ack; a same-cycle ack under jr is dropped.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    pc4_nx   = pc_plus4_out;
    ins_nx   = ins_out;
    valid_nx = valid_out;
    load     = 1'b0;
    take     = 1'b0;
    flush    = 1'b0;
    fetch    = 1'b0;
    if (state == S_RESET) begin
      state_nx = S_FETCH;
    end else if (jr_in) begin
      flush    = 1'b1;
      pc_nx    = {jr_target_in[31:2], 2'b00};
      ins_nx   = NOP_INS;
      valid_nx = 1'b0;
      state_nx = S_FETCH;
    end else if (stall_in) begin
      load     = state == S_FETCH && imem_ack_in;
      state_nx = load ? S_HOLD : state;
    end else if (state == S_HOLD || imem_ack_in) begin
      take     = skid_valid;
      fetch    = 1'b1;
      ins_nx   = skid_valid ? skid : imem_rdata_in;
      pc_nx    = pc + PC_INC;
      pc4_nx   = pc + PC_INC;
      valid_nx = 1'b1;
      state_nx = S_FETCH;
    end else begin
      ins_nx   = NOP_INS;
      valid_nx = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RESET;
      pc           <= RESET_PC;
      ins_out      <= NOP_INS;
      pc_plus4_out <= 32'h0;
      valid_out    <= 1'b0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      ins_out      <= ins_nx;
      pc_plus4_out <= pc4_nx;
      valid_out    <= valid_nx;
    end
  end
`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_out <= '0;
      flush_count_out <= '0;
    end else begin
      if (fetch && fetch_count_out != '1) fetch_count_out <= fetch_count_out + CNT_W'(1);
      if (flush && flush_count_out != '1) flush_count_out <= flush_count_out + CNT_W'(1);
    end
  end
`endif
endmodule
